cache_mem_arbiter: RTL

// - Shares the single burst memory port between the icache and dcache line-miss ports.
// - Sits between the two caches and the cacheline adaptor, at the mp4 top level.
// - Serves one whole-line transaction at a time. dcache has priority.
// - Bounded anti-starvation guarantees icache progress.

---
 rtl/cache_mem_arbiter_pkg.sv | 31 +++
 rtl/cache_mem_arbiter_arb_select.sv | 29 ++
 rtl/cache_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Purpose: shared types for the cache/memory arbiter, cacheline adaptor and cache control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_types;

    localparam int DEF_LINE_W    = 256;
    localparam int DEF_ADDR_W    = 32;
    localparam int LINE_OFFSET_W = $clog2(DEF_LINE_W / 8);

    // Wide enough for the largest allowed starvation limit (15).
    localparam int STARVE_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        ICACHE = 2'b01,
        DCACHE = 2'b10
    } arb_grant_t;

    // Byte-offset width of a cache line for an arbitrary line width.
    function automatic int line_offset_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_arb_select.sv
// Purpose: picks the winning cache port from the live requests and the starvation count.
// Latency: purely combinational.
// Backpressure: none; the caller only consults the result while idle.
module arb_select
    import arb_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_req_i,
    input  logic                    d_req_i,
    input  logic [STARVE_CNT_W-1:0] starve_cnt_i,
    output arb_grant_t              winner_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    // dcache wins contention unless icache has already been passed over LIMIT times.
    always_comb begin
        winner_o = NONE;
        if (i_req_i && d_req_i) begin
            winner_o = (starve_cnt_i == LIMIT) ? ICACHE : DCACHE;
        end else if (d_req_i) begin
            winner_o = DCACHE;
        end else if (i_req_i) begin
            winner_o = ICACHE;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Purpose: shares one burst memory port between icache and dcache line misses, dcache first.
// Latency: request seen in cycle N -> mem strobe in N+1; resp one cycle after mem_resp.
// Backpressure: requests are held by the caches until their resp; mem side waits on mem_resp.
module cache_mem_arbiter
    import arb_types::*;
#(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,

    output logic              busy,
    output logic [1:0]        grant
);

    localparam int OFF_W = line_offset_w(LINE_W);

    // Clears the byte-offset bits so the memory side always sees line-aligned addresses.
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_t              state_q;
    arb_grant_t              grant_q;
    logic                    busy_q;
    logic [STARVE_CNT_W-1:0] starve_q;
    logic [STARVE_CNT_W-1:0] starve_d;

    logic                    mem_read_q;
    logic                    mem_write_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [LINE_W-1:0]       mem_wdata_q;

    logic [LINE_W-1:0]       i_rdata_q;
    logic [LINE_W-1:0]       d_rdata_q;
    logic                    i_resp_q;
    logic                    d_resp_q;

    logic                    d_req;
    logic [ADDR_W-1:0]       i_line_addr;
    logic [ADDR_W-1:0]       d_line_addr;
    arb_grant_t              winner;

    // A simultaneous read+write from dcache is treated as a writeback (write wins).
    always_comb begin
        d_req       = d_read | d_write;
        i_line_addr = i_address & LINE_MASK;
        d_line_addr = d_address & LINE_MASK;
    end

    arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .i_req_i      (i_read),
        .d_req_i      (d_req),
        .starve_cnt_i (starve_q),
        .winner_o     (winner)
    );

    // Starvation count: bumps when dcache wins over a waiting icache, clears on any icache grant.
    always_comb begin
        starve_d = starve_q;
        if (winner == ICACHE) begin
            starve_d = '0;
        end else if ((winner == DCACHE) && i_read && (starve_q < LIMIT)) begin
            starve_d = starve_q + STARVE_CNT_W'(1);
        end
    end

    // Arbiter FSM: grants in IDLE, holds the registered memory request, pulses resp, returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= NONE;
            busy_q      <= 1'b0;
            starve_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
        end else begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    starve_q <= starve_d;
                    case (winner)
                        ICACHE: begin
                            state_q     <= GNT_I;
                            grant_q     <= ICACHE;
                            busy_q      <= 1'b1;
                            mem_read_q  <= 1'b1;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= i_line_addr;
                            mem_wdata_q <= '0;
                        end
                        DCACHE: begin
                            state_q     <= GNT_D;
                            grant_q     <= DCACHE;
                            busy_q      <= 1'b1;
                            mem_read_q  <= ~d_write;
                            mem_write_q <= d_write;
                            mem_addr_q  <= d_line_addr;
                            mem_wdata_q <= d_wdata;
                        end
                        default: ;
                    endcase
                end
                GNT_I: begin
                    if (mem_resp) begin
                        i_rdata_q   <= mem_rdata;
                        i_resp_q    <= 1'b1;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= RESP;
                    end
                end
                GNT_D: begin
                    if (mem_resp) begin
                        d_rdata_q   <= mem_rdata;
                        d_resp_q    <= 1'b1;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    // Requester drops its request during this cycle; re-arbitrate from IDLE.
                    state_q <= IDLE;
                    grant_q <= NONE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata     = i_rdata_q;
    assign i_resp      = i_resp_q;
    assign d_rdata     = d_rdata_q;
    assign d_resp      = d_resp_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign grant       = grant_q;

endmodule
